mips_multicycle_controller: RTL
===============================

# mips_multicycle_controller

Control FSM for the multicycle MIPS datapath. It sequences one shared memory, one ALU and the register file over 3–5 cycles per instruction, and it replaces the single-cycle decode path. The block holds a registered state and derives all datapath enables and mux selects from that state. It also generates the ALU operation from Opcode/Funct and stalls on a memory-ready handshake.

## Interface
- No parameters.
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-low reset. One clock domain.
- Opcode  in  6  instr[31:26]. Sampled from the instruction register in DECODE.
- Funct  in  6  instr[5:0].
- Zero  in  1  ALU zero flag, same cycle.
- MemReady  in  1  memory access complete this cycle.
- MemRead, MemWrite, IRWrite, IorD  out  1 each  memory-side controls.
- PCEn  out  1  PC register enable. PCEn = PCWrite | (Branch & Zero).
- PCSrc  out  2  00 ALUResult, 01 ALUOut, 10 jump target.
- ALUSrcA  out  1  0 PC, 1 regA.
- ALUSrcB  out  2  00 regB, 01 constant 4, 10 SignImm, 11 SignImm<<2.
- ALUControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- RegDst, MemtoReg, RegWrite  out  1 each  register-file controls.
- Illegal  out  1  one-cycle pulse: unsupported opcode.
- State  out  4  current state, for debug and bench use.

## Operation
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Codes 12–15 are unreachable and go to FETCH.
- All outputs are combinational from State, plus MemReady, Funct and Zero where noted. Any control not listed for a state is 0, and ALUOp is 00 by default.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite=PCWrite=MemReady.
  - Next state: DECODE if MemReady=1, else FETCH.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - Next state by opcode: 100011 or 101011 → MEMADR; 000000 → EXEC; 000100 → BRANCH; 001000 → ADDIEX; 000010 → JUMP.
  - Any other opcode: Illegal=1, next state FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: MEMRD if Opcode=100011, else MEMWR.
- MEMRD: MemRead=1, IorD=1. Next: MEMWB when MemReady=1, else hold.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next: FETCH.
- MEMWR: MemWrite=1, IorD=1. Next: FETCH when MemReady=1, else hold. MemWrite stays high throughout the wait.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Next: FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1. Next: FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Next: FETCH.
- JUMP: PCSrc=10, PCWrite=1. Next: FETCH.
- ALUControl mapping:
  - ALUOp 00 → 010; ALUOp 01 → 110.
  - ALUOp 10 decodes Funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111, any other→010.
  - An unknown Funct does not raise Illegal.

## Timing
- RST low forces State=FETCH immediately, independent of CLK. All outputs then show the FETCH decode: MemRead=1, ALUSrcB=01, ALUControl=010, IRWrite=PCEn=MemReady, everything else 0.
- The first transition happens on the first rising CLK edge after RST deasserts.
- Cycles per instruction with MemReady held at 1:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
  - Each cycle with MemReady=0 in FETCH, MEMRD or MEMWR adds one cycle.
- PCEn asserts for exactly one cycle per instruction in FETCH, the one where MemReady=1. It asserts again in JUMP, and in BRANCH only when Zero=1.
- RegWrite asserts for exactly one cycle per lw, R-type or addi, and never during a stall.
- Reset asserted mid-instruction abandons the instruction. No write strobe may remain asserted after RST falls.
- Illegal is high only during the DECODE cycle. It costs 2 cycles in total and causes no register or memory write.

## Test plan
- Reset, then MemReady=1 and an lw (100011) opcode → State sequence 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 only in state 4.
- sw with MemReady=0 for 3 cycles in MEMWR → State holds at 5 for 4 cycles with MemWrite=1 throughout, then returns to 0. RegWrite is never 1.
- beq (000100) → in state 8, Zero=1 gives PCEn=1 and PCSrc=01; Zero=0 gives PCEn=0.
- R-type with Funct 100010 then 101010 → ALUControl=110 and then 111 in EXEC. Each instruction takes 4 cycles and ALUWB has RegDst=1.
- Opcode 111111 → Illegal=1 for one cycle in DECODE, next State=0, and no RegWrite, MemWrite or PCEn in that cycle.
- RST pulled low during MEMWR while MemReady=0 → State=0 and MemWrite=0 without a clock edge. After release, a j (000010) completes in 3 cycles with PCSrc=10.

Source files
------------

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control FSM: each instruction takes 3-5 states, and all controls are decoded from the current state.
// FETCH, MEMRD and MEMWR hold until MemReady; every other state advances on each clock.
module mips_multicycle_controller (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       IorD,
  output logic       PCEn,
  output logic [1:0] PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     state;
  state_t     next_state;
  logic       pcwrite;
  logic       branch;
  logic [1:0] aluop;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= FETCH;
    else      state <= next_state;
  end

  always_comb begin
    next_state = FETCH;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    IorD       = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    PCSrc      = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    aluop      = 2'b00;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    Illegal    = 1'b0;
    case (state)
      FETCH: begin
        MemRead    = 1'b1;
        ALUSrcB    = 2'b01;
        IRWrite    = MemReady;
        pcwrite    = MemReady;
        next_state = MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = EXEC;
          OP_BEQ:       next_state = BRANCH;
          OP_ADDI:      next_state = ADDIEX;
          OP_J:         next_state = JUMP;
          default: begin
            Illegal    = 1'b1;
            next_state = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        next_state = (Opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        MemRead    = 1'b1;
        IorD       = 1'b1;
        next_state = MemReady ? MEMWB : MEMRD;
      end
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      // MemWrite is held for the whole wait so the memory sees a stable request.
      MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        next_state = MemReady ? FETCH : MEMWR;
      end
      EXEC: begin
        ALUSrcA    = 1'b1;
        aluop      = 2'b10;
        next_state = ALUWB;
      end
      ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        aluop   = 2'b01;
        PCSrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        next_state = ADDIWB;
      end
      ADDIWB: RegWrite = 1'b1;
      JUMP: begin
        PCSrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: next_state = FETCH;
    endcase
  end

  // An unknown Funct falls back to add rather than flagging Illegal.
  always_comb begin
    ALUControl = 3'b010;
    case (aluop)
      2'b01: ALUControl = 3'b110;
      2'b10: begin
        case (Funct)
          6'b100010: ALUControl = 3'b110;
          6'b100100: ALUControl = 3'b000;
          6'b100101: ALUControl = 3'b001;
          6'b101010: ALUControl = 3'b111;
          default:   ALUControl = 3'b010;
        endcase
      end
      default: ALUControl = 3'b010;
    endcase
  end

  assign PCEn  = pcwrite | (branch & Zero);
  assign State = state;

endmodule
